// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg : shared op encodings, FSM state type and default width for the
//              EX-stage multiply/divide unit.   Rev 1.0
// ============================================================================
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// ex_muldiv_unit_if : ID/EX-side request, MTHI/MTLO and HI/LO/status bundle.
//                     Rev 1.0
// ============================================================================
interface ex_muldiv_unit_if #(
    parameter int WIDTH = muldiv_pkg::DEFAULT_WIDTH
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] Rdata1in;
    logic [WIDTH-1:0] Rdata2in;
    logic             hi_we;
    logic             lo_we;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, op, Rdata1in, Rdata2in, hi_we, lo_we, flush,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, Rdata1in, Rdata2in, hi_we, lo_we, flush,
        output hi, lo, busy, done, stall
    );

endinterface
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
// muldiv_core : unsigned shift-add multiply / restoring divide datapath,
//               one bit per step.   Rev 1.0
// ============================================================================
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic             step,
    input  wire logic             div_sel,
    input  wire logic [WIDTH-1:0] a_mag,
    input  wire logic [WIDTH-1:0] b_mag,
    output logic      [WIDTH-1:0] acc,
    output logic      [WIDTH-1:0] quo
);

    // r_acc/r_q form the 2*WIDTH product for multiply, remainder/quotient for divide
    logic             r_div;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_mag;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_mag};
    assign w_shift = {r_acc, r_q[WIDTH-1]};
    // Remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow flag
    assign w_diff  = w_shift - {1'b0, r_mag};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= 1'b0;
            r_acc <= '0;
            r_q   <= '0;
            r_mag <= '0;
        end else if (load) begin
            r_div <= div_sel;
            r_acc <= '0;
            r_q   <= div_sel ? a_mag : b_mag;
            r_mag <= div_sel ? b_mag : a_mag;
        end else if (step) begin
            if (r_div) begin
                if (!w_diff[WIDTH]) begin
                    r_acc <= w_diff[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_acc <= w_shift[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], 1'b0};
                end
            end else if (r_q[0]) begin
                {r_acc, r_q} <= {w_sum, r_q[WIDTH-1:1]};
            end else begin
                {r_acc, r_q} <= {1'b0, r_acc, r_q[WIDTH-1:1]};
            end
        end
    end

    assign acc = r_acc;
    assign quo = r_q;

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// ex_muldiv_unit : EX-stage iterative MULT/MULTU/DIV/DIVU with HI/LO ownership
//                  and pipeline stall generation.   Rev 1.0
// ============================================================================
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input wire logic          clk,
    input wire logic          rst,
    ex_muldiv_unit_if.slave   bus
);

    localparam int c_CNT_W = $clog2(WIDTH);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;

    logic                 w_open;
    logic                 w_accept;
    logic                 w_div0;
    logic                 w_load;
    logic                 w_signed;
    logic [WIDTH-1:0]     w_rs;
    logic [WIDTH-1:0]     w_rt;
    logic [WIDTH-1:0]     w_rs_mag;
    logic [WIDTH-1:0]     w_rt_mag;
    logic [WIDTH-1:0]     w_acc;
    logic [WIDTH-1:0]     w_quo;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    assign w_rs     = bus.Rdata1in;
    assign w_rt     = bus.Rdata2in;
    assign w_signed = op_is_signed(bus.op);
    assign w_open   = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept = bus.start && !bus.flush && w_open;
    assign w_div0   = op_is_div(bus.op) && (w_rt == '0);
    assign w_load   = w_accept && !w_div0;

    // Magnitudes of the most negative value wrap onto themselves, which is the correct unsigned magnitude
    assign w_rs_mag = (w_signed && w_rs[WIDTH-1]) ? -w_rs : w_rs;
    assign w_rt_mag = (w_signed && w_rt[WIDTH-1]) ? -w_rt : w_rt;

    muldiv_core #(
        .WIDTH   (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .step    (r_state == ST_CALC),
        .div_sel (op_is_div(bus.op)),
        .a_mag   (w_rs_mag),
        .b_mag   (w_rt_mag),
        .acc     (w_acc),
        .quo     (w_quo)
    );

    assign w_prod     = {w_acc, w_quo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_res_hi   = r_is_div ? (r_neg_r ? -w_acc : w_acc) : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_res_lo   = r_is_div ? (r_neg_q ? -w_quo : w_quo) : w_prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_open && bus.hi_we) r_hi <= w_rs;
            if (w_open && bus.lo_we) r_lo <= w_rs;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (w_accept) begin
                        r_is_div <= op_is_div(bus.op);
                        r_neg_q  <= w_signed && (w_rs[WIDTH-1] ^ w_rt[WIDTH-1]);
                        r_neg_r  <= w_signed && w_rs[WIDTH-1];
                        if (w_div0) begin
                            // Later assignments win over a coincident MTHI/MTLO
                            r_hi    <= w_rs;
                            r_lo    <= '1;
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt   <= c_CNT_W'(WIDTH - 1);
                            r_state <= ST_CALC;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    if (bus.flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_SIGN;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SIGN: begin
                    r_busy <= 1'b0;
                    if (bus.flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.stall = r_busy || w_load;

endmodule
`default_nettype wire
